// File: rtl/uart_fifo.sv
// UART transceiver with first-word-fall-through TX and RX FIFOs on a single clock.
// Optional feature macro: UART_PARITY_EN adds one parity bit per frame (odd when PARITY_ODD=1).
module uart_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int DEPTH      = 16,
    parameter int PARITY_ODD = 0,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [LW-1:0]        tx_level,
    output logic [LW-1:0]        rx_level,
    output logic                 tx_busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DIV);
    localparam int HALF = DIV / 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PAR,
`endif
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] tx_mem [DEPTH];
    logic [AW-1:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [LW-1:0]        tx_lvl_q, tx_lvl_d;
    logic                 tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_ready = (tx_lvl_q != LW'(DEPTH));
    assign tx_push  = tx_valid && tx_ready;
    assign tx_head  = tx_mem[tx_rd_q];
    assign tx_level = tx_lvl_q;

    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_lvl_d = tx_lvl_q;
        if (tx_push) tx_wr_d = tx_wr_q + AW'(1);
        if (tx_pop)  tx_rd_d = tx_rd_q + AW'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_lvl_d = tx_lvl_q + LW'(1);
            2'b01:   tx_lvl_d = tx_lvl_q - LW'(1);
            default: tx_lvl_d = tx_lvl_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_lvl_q <= '0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_lvl_q <= tx_lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= tx_data;
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    state_t               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_q, tx_d;
    logic                 tx_last, tx_load;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    assign tx_last = (tx_cnt_q == CW'(DIV - 1));
    assign tx      = tx_q;
    assign tx_busy = (tx_state_q != IDLE) || (tx_lvl_q != '0);

    // tx is registered so the line changes exactly on state-transition edges
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_last ? '0 : tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (tx_lvl_q != '0) tx_load = 1'b1;
            end
            START: begin
                if (tx_last) begin
                    tx_state_d = DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_sh_q[0];
                end
            end
            DATA: begin
                if (tx_last) begin
                    tx_sh_d = tx_sh_q >> 1;
                    if (tx_bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        tx_state_d = PAR;
                        tx_d       = tx_par_q;
`else
                        tx_state_d = STOP;
                        tx_bit_d   = '0;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_d     = tx_sh_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            PAR: begin
                if (tx_last) begin
                    tx_state_d = STOP;
                    tx_bit_d   = '0;
                    tx_d       = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tx_last) begin
                    if (tx_bit_q == 3'(STOP_BITS - 1)) begin
                        if (tx_lvl_q != '0) begin
                            tx_load = 1'b1;
                        end else begin
                            tx_state_d = IDLE;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            default: begin
                tx_state_d = IDLE;
                tx_cnt_d   = '0;
                tx_d       = 1'b1;
            end
        endcase

        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_state_d = START;
            tx_cnt_d   = '0;
            tx_d       = 1'b0;
`ifdef UART_PARITY_EN
            tx_par_d   = (^tx_head) ^ (PARITY_ODD != 0);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser and FIFO
    // ------------------------------------------------------------------
    logic [1:0]           sync_q, sync_d;
    logic                 rx_s;
    logic [DATA_BITS-1:0] rx_mem [DEPTH];
    logic [AW-1:0]        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [LW-1:0]        rx_lvl_q, rx_lvl_d;
    logic                 rx_push, rx_pop;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;

    assign sync_d   = {sync_q[0], rx};
    assign rx_s     = sync_q[1];
    assign rx_valid = (rx_lvl_q != '0);
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_data  = rx_mem[rx_rd_q];
    assign rx_level = rx_lvl_q;

    always_comb begin
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_lvl_d = rx_lvl_q;
        if (rx_push) rx_wr_d = rx_wr_q + AW'(1);
        if (rx_pop)  rx_rd_d = rx_rd_q + AW'(1);
        case ({rx_push, rx_pop})
            2'b10:   rx_lvl_d = rx_lvl_q + LW'(1);
            2'b01:   rx_lvl_d = rx_lvl_q - LW'(1);
            default: rx_lvl_d = rx_lvl_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= 2'b11;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_lvl_q <= '0;
        end else begin
            sync_q   <= sync_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_lvl_q <= rx_lvl_d;
        end
    end

    // When full, a write only lands in the slot being popped in the same cycle
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_q] <= rx_sh_q;
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    state_t        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic          rx_brk_q, rx_brk_d;
    logic          rx_mid, rx_last;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
`ifdef UART_PARITY_EN
    logic          rx_pbit_q, rx_pbit_d;
    logic          parity_err_q, parity_err_d;
    logic          rx_par_exp;

    assign rx_par_exp = (^rx_sh_q) ^ (PARITY_ODD != 0);
    assign parity_err = parity_err_q;
`else
    logic          unused_parity_cfg;

    assign unused_parity_cfg = (PARITY_ODD != 0);
    assign parity_err        = 1'b0;
`endif

    assign rx_mid    = (rx_cnt_q == CW'(HALF));
    assign rx_last   = (rx_cnt_q == CW'(DIV - 1));
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // A byte is accepted at mid-stop so a following start edge is never missed;
    // after a framing error the FSM parks in STOP until the line returns high.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_last ? '0 : rx_cnt_q + CW'(1);
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_brk_d    = rx_brk_q;
        rx_push     = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_PARITY_EN
        rx_pbit_d    = rx_pbit_q;
        parity_err_d = 1'b0;
`endif
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s) rx_state_d = START;
            end
            START: begin
                if (rx_mid && rx_s) begin
                    rx_state_d = IDLE;
                    rx_cnt_d   = '0;
                end else if (rx_last) begin
                    rx_state_d = DATA;
                    rx_bit_d   = '0;
                end
            end
            DATA: begin
                if (rx_mid) rx_sh_d = {rx_s, rx_sh_q[DATA_BITS-1:1]};
                if (rx_last) begin
                    if (rx_bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        rx_state_d = PAR;
`else
                        rx_state_d = STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PAR: begin
                if (rx_mid) rx_pbit_d = rx_s;
                if (rx_last) rx_state_d = STOP;
            end
`endif
            STOP: begin
                if (rx_brk_q) begin
                    rx_cnt_d = '0;
                    if (rx_s) begin
                        rx_state_d = IDLE;
                        rx_brk_d   = 1'b0;
                    end
                end else if (rx_mid) begin
                    rx_cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        rx_brk_d    = 1'b1;
`ifdef UART_PARITY_EN
                    end else if (rx_pbit_q != rx_par_exp) begin
                        parity_err_d = 1'b1;
                        rx_state_d   = IDLE;
`endif
                    end else begin
                        rx_state_d = IDLE;
                        if (rx_lvl_q == LW'(DEPTH) && !rx_pop) overrun_d = 1'b1;
                        else                                    rx_push   = 1'b1;
                    end
                end
            end
            default: begin
                rx_state_d = IDLE;
                rx_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q  <= IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            rx_brk_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_pbit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            rx_brk_q    <= rx_brk_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
            rx_pbit_q    <= rx_pbit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo at DIV=8, DATA_BITS=8, DEPTH=4, STOP_BITS=1.
// Frame vectors come from a table; loopback traffic is checked against a byte-queue model.
module tb_uart_fifo;

    localparam int DIV   = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          rx;
    logic          tx;
    logic [7:0]    tx_data  = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          tx_busy;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;

    logic          loop_en = 1'b0;
    logic          rx_drv  = 1'b1;

    int checks  = 0;
    int errors  = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int pe_seen = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } tx_vec_t;

    tx_vec_t vecs [4];

    assign rx = loop_en ? tx : rx_drv;

    uart_fifo #(
        .CLK_FREQ  (800),
        .BAUD      (100),
        .DATA_BITS (8),
        .STOP_BITS (1),
        .DEPTH     (DEPTH),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .tx        (tx),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_level  (tx_level),
        .rx_level  (rx_level),
        .tx_busy   (tx_busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Pulses last one full cycle, so each is counted exactly once on the falling edge
    always @(negedge clk) begin
        if (frame_err)  fe_seen++;
        if (overrun)    ov_seen++;
        if (parity_err) pe_seen++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue one byte into the TX FIFO; returns one tick after the accepting edge
    task automatic applyStimulus(input logic [7:0] d);
        int guard = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && guard < 400) begin
            wait_cycles(1);
            guard++;
        end
        if (guard >= 400) checkOutput("push_ready_timeout", 32'(tx_ready), 32'd1);
        wait_cycles(1);
        tx_valid = 1'b0;
    endtask

    task automatic send_serial(input logic [7:0] d, input logic stop_level);
        rx_drv = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            wait_cycles(DIV);
        end
        rx_drv = stop_level;
        wait_cycles(DIV);
        rx_drv = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (tx_busy && guard < 1000) begin
            wait_cycles(1);
            guard++;
        end
        if (guard >= 1000) checkOutput(name, 32'(tx_busy), 32'd0);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(1);
    endtask

    task automatic run_table();
        logic [9:0] wa, wb;
        logic       busy_before, busy_after, tx_after;
        for (int v = 0; v < 4; v++) begin
            wa = '0;
            wb = '0;
            busy_before = 1'b0;
            busy_after  = 1'b1;
            tx_after    = 1'b0;
            applyStimulus(vecs[v].data);
            checkOutput($sformatf("vec%0d_level_after_push", v), 32'(tx_level), 32'd1);
            for (int c = 1; c <= 81; c++) begin
                wait_cycles(1);
                if (c <= 80) begin
                    if ((c - 1) % 8 == 1) wa[(c - 1) / 8] = tx;
                    if ((c - 1) % 8 == 6) wb[(c - 1) / 8] = tx;
                end
                if (c == 80) busy_before = tx_busy;
                if (c == 81) begin
                    busy_after = tx_busy;
                    tx_after   = tx;
                end
            end
            checkOutput($sformatf("vec%0d_frame_early", v), 32'(wa), 32'(vecs[v].frame));
            checkOutput($sformatf("vec%0d_frame_late", v), 32'(wb), 32'(vecs[v].frame));
            checkOutput($sformatf("vec%0d_busy_at_80", v), 32'(busy_before), 32'd1);
            checkOutput($sformatf("vec%0d_busy_at_81", v), 32'(busy_after), 32'd0);
            checkOutput($sformatf("vec%0d_tx_idle", v), 32'(tx_after), 32'd1);
        end
    endtask

    task automatic run_back_to_back();
        logic [7:0]  bytes [5];
        logic [49:0] bits;
        logic        saw_full;
        int          g;
        bytes[0] = 8'h11; bytes[1] = 8'hC4; bytes[2] = 8'h7E;
        bytes[3] = 8'h80; bytes[4] = 8'h2B;
        saw_full = 1'b0;
        bits     = '0;
        fork
            begin
                for (int i = 0; i < 5; i++) applyStimulus(bytes[i]);
            end
            begin
                g = 0;
                while (tx !== 1'b0 && g < 30) begin
                    wait_cycles(1);
                    g++;
                end
                if (g >= 30) checkOutput("b2b_start_seen", 32'(tx), 32'd0);
                wait_cycles(3);
                bits[0] = tx;
                for (int i = 1; i < 50; i++) begin
                    wait_cycles(DIV);
                    bits[i] = tx;
                end
            end
            begin
                for (int i = 0; i < 120; i++) begin
                    wait_cycles(1);
                    if (!tx_ready && tx_level == LW'(DEPTH)) saw_full = 1'b1;
                end
            end
        join
        checkOutput("b2b_full_seen", 32'(saw_full), 32'd1);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("b2b_frame%0d", i), 32'(bits[10*i +: 10]), 32'({1'b1, bytes[i], 1'b0}));
        wait_idle("b2b_idle_timeout");
        checkOutput("b2b_level_drained", 32'(tx_level), 32'd0);
    endtask

    task automatic run_loopback_single();
        int guard = 0;
        loop_en = 1'b1;
        applyStimulus(8'hA3);
        while (!rx_valid && guard < 200) begin
            wait_cycles(1);
            guard++;
        end
        checkOutput("lb_valid", 32'(rx_valid), 32'd1);
        checkOutput("lb_data", 32'(rx_data), 32'hA3);
        checkOutput("lb_level", 32'(rx_level), 32'd1);
        pop_one();
        checkOutput("lb_level_after_pop", 32'(rx_level), 32'd0);
        wait_idle("lb_idle_timeout");
        loop_en = 1'b0;
    endtask

    task automatic run_random_loopback(input int n);
        logic [7:0] exp_q [$];
        logic [7:0] expected;
        int sent = 0;
        int recv = 0;
        int guard = 0;
        int fe0 = fe_seen;
        int ov0 = ov_seen;
        loop_en = 1'b1;
        while (recv < n && guard < 20000) begin
            if (sent < n && $urandom_range(0, 3) == 0) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom_range(0, 255));
            end else begin
                tx_valid = 1'b0;
            end
            rx_ready = ($urandom_range(0, 1) == 1);
            if (tx_valid && tx_ready) begin
                exp_q.push_back(tx_data);
                sent++;
            end
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rnd_spurious_valid", 32'(rx_valid), 32'd0);
                end else begin
                    expected = exp_q.pop_front();
                    checkOutput($sformatf("rnd_byte%0d", recv), 32'(rx_data), 32'(expected));
                end
                recv++;
            end
            wait_cycles(1);
            guard++;
        end
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        checkOutput("rnd_received_count", 32'(recv), 32'(n));
        checkOutput("rnd_no_errors", 32'((fe_seen - fe0) + (ov_seen - ov0)), 32'd0);
        wait_idle("rnd_idle_timeout");
        loop_en = 1'b0;
    endtask

    task automatic run_glitch();
        logic saw_valid = 1'b0;
        int   fe0 = fe_seen;
        rx_drv = 1'b0;
        wait_cycles(3);
        rx_drv = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wait_cycles(1);
            if (rx_valid) saw_valid = 1'b1;
        end
        checkOutput("glitch_no_valid", 32'(saw_valid), 32'd0);
        checkOutput("glitch_no_frame_err", 32'(fe_seen - fe0), 32'd0);
    endtask

    task automatic run_frame_error();
        logic saw_valid = 1'b0;
        int   fe0 = fe_seen;
        send_serial(8'h3C, 1'b0);
        for (int i = 0; i < 40; i++) begin
            wait_cycles(1);
            if (rx_valid) saw_valid = 1'b1;
        end
        checkOutput("ferr_pulse_count", 32'(fe_seen - fe0), 32'd1);
        checkOutput("ferr_level", 32'(rx_level), 32'd0);
        checkOutput("ferr_no_valid", 32'(saw_valid), 32'd0);
    endtask

    task automatic run_overrun();
        logic [7:0] exp_q [$];
        logic [7:0] b;
        logic [7:0] expected;
        int ov0 = ov_seen;
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_serial(b, 1'b1);
        end
        checkOutput("ovr_none_before_5th", 32'(ov_seen - ov0), 32'd0);
        checkOutput("ovr_level_full", 32'(rx_level), 32'd4);
        send_serial(8'h5A, 1'b1);
        wait_cycles(4);
        checkOutput("ovr_pulse_count", 32'(ov_seen - ov0), 32'd1);
        checkOutput("ovr_level_after", 32'(rx_level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            expected = exp_q.pop_front();
            checkOutput($sformatf("ovr_head%0d", i), 32'(rx_data), 32'(expected));
            pop_one();
        end
        checkOutput("ovr_drained", 32'(rx_valid), 32'd0);
    endtask

    task automatic run_reset_midframe();
        logic tx_dropped  = 1'b0;
        logic saw_valid   = 1'b0;
        int   fe0 = fe_seen;
        loop_en = 1'b1;
        applyStimulus(8'hF0);
        applyStimulus(8'h0F);
        wait_cycles(30);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_tx_high", 32'(tx), 32'd1);
        checkOutput("rst_mid_tx_level", 32'(tx_level), 32'd0);
        checkOutput("rst_mid_busy", 32'(tx_busy), 32'd0);
        wait_cycles(2);
        reset = 1'b0;
        for (int i = 0; i < 150; i++) begin
            wait_cycles(1);
            if (!tx)      tx_dropped = 1'b1;
            if (rx_valid) saw_valid  = 1'b1;
        end
        checkOutput("rst_mid_tx_stays_high", 32'(tx_dropped), 32'd0);
        checkOutput("rst_mid_no_rx_byte", 32'(saw_valid), 32'd0);
        checkOutput("rst_mid_no_frame_err", 32'(fe_seen - fe0), 32'd0);
        loop_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h55, 10'b1_01010101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'hA3, 10'b1_10100011_0};

        wait_cycles(2);
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst_tx_level", 32'(tx_level), 32'd0);
        checkOutput("rst_rx_level", 32'(rx_level), 32'd0);
        checkOutput("rst_tx_busy", 32'(tx_busy), 32'd0);
        checkOutput("rst_pulses", 32'({frame_err, overrun, parity_err}), 32'd0);
        do_reset();

        $display("[TB] table-driven TX frames");
        run_table();
        $display("[TB] back-to-back TX");
        run_back_to_back();
        $display("[TB] loopback single byte");
        run_loopback_single();
        $display("[TB] randomized loopback");
        run_random_loopback(12);
        $display("[TB] RX glitch");
        run_glitch();
        $display("[TB] RX framing error");
        run_frame_error();
        $display("[TB] RX overrun");
        run_overrun();
        $display("[TB] reset mid-frame");
        run_reset_midframe();
        checkOutput("parity_err_never", 32'(pe_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, input clock in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate; DIV = CLK_FREQ/BAUD clocks per bit, DIV >= 4.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter STOP_BITS, default 1, transmitted stop bits, legal values 1 or 2.
REQ-005 SHALL have parameter DEPTH, default 16, entries per FIFO, power of two, >= 2; LW = log2(DEPTH)+1.
REQ-006 SHALL have parameter PARITY_ODD, default 0; 1 selects odd parity, 0 selects even; used only under UART_PARITY_EN.
REQ-007 SHALL have port clk, input, 1 bit, single clock; one clock, reset asynchronous active-high.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL have port rx, input, 1 bit, serial line in, idle high, asynchronous to clk.
REQ-010 SHALL have port tx, output, 1 bit, serial line out, idle high.
REQ-011 SHALL have port tx_data, input, DATA_BITS bits, byte to queue.
REQ-012 SHALL have ports tx_valid (input) and tx_ready (output), 1 bit each; a push occurs when both are high on a clk edge.
REQ-013 SHALL have port rx_data, output, DATA_BITS bits, RX FIFO head.
REQ-014 SHALL have ports rx_valid (output) and rx_ready (input), 1 bit each; a pop occurs when both are high on a clk edge.
REQ-015 SHALL have ports tx_level and rx_level, outputs, LW bits each, FIFO occupancy.
REQ-016 SHALL have port tx_busy, output, 1 bit; high while a frame is on the line or the TX FIFO is non-empty.
REQ-017 SHALL have ports frame_err, overrun and parity_err, outputs, 1 bit each, single-cycle pulses.

Function
REQ-018 SHALL drive tx_ready = (tx_level != DEPTH) and rx_valid = (rx_level != 0); rx_data SHALL be valid combinationally whenever rx_valid is high (first-word fall-through).
REQ-019 SHALL implement a TX FSM with states IDLE, START, DATA, PAR, STOP; each state lasts exactly DIV clocks per bit.
REQ-020 SHALL move from IDLE to START on the clock after the TX FIFO becomes non-empty, popping one entry; tx SHALL go low on that same edge.
REQ-021 SHALL transmit data LSB first, then PAR when enabled, then STOP_BITS high bits; after STOP it SHALL go to START directly if the FIFO is non-empty, otherwise to IDLE.
REQ-022 SHALL pass rx through a 2-flop synchroniser; the RX FSM SHALL use states IDLE, START, DATA, PAR, STOP.
REQ-023 SHALL sample each RX bit at count DIV/2 of its bit period; if the start bit samples high, it SHALL return to IDLE with no flag (glitch rejection).
REQ-024 SHALL check one stop bit; if it samples low, SHALL pulse frame_err, discard the byte, and wait for rx high before re-entering IDLE.
REQ-025 SHALL, when a good byte completes with the RX FIFO full and no pop that cycle, pulse overrun and drop the new byte; with a simultaneous pop, it SHALL accept the byte and rx_level SHALL stay unchanged.
REQ-026 SHALL allow a simultaneous push and pop on either FIFO; the level SHALL stay unchanged.
REQ-027 SHALL use FIFO pointers of width log2(DEPTH) that wrap modulo DEPTH.

Reset
REQ-028 SHALL on reset set tx=1, tx_ready=1, rx_valid=0, levels=0, tx_busy=0, all error pulses 0, both FSMs to IDLE, and synchroniser flops to 1.
REQ-029 SHALL, when reset asserts mid-frame, force tx high immediately, discard both FIFO contents, and emit no partial byte or flag.

Configuration
REQ-030 SHALL, with UART_PARITY_EN defined, send and check one parity bit after the data bits; on mismatch it SHALL pulse parity_err and discard the byte.
REQ-031 SHALL, without UART_PARITY_EN, omit the PAR states and tie parity_err to 0.

Verification (DIV=8, DATA_BITS=8, DEPTH=4, STOP_BITS=1)
REQ-032 Push 0x55 -> tx low 8 clks, then 1,0,1,0,1,0,1,0 at 8 clks each, then high; tx_busy falls after 80 clks.
REQ-033 Push 5 bytes back-to-back -> tx_ready low once 4 are queued after the first pop; frames are contiguous with no idle gap.
REQ-034 Loop tx to rx, send 0xA3 -> rx_valid high with rx_data=0xA3 and rx_level=1.
REQ-035 Drive a 3-clk low glitch on rx -> no rx_valid, no frame_err.
REQ-036 Drive a frame of 0x3C with stop bit low -> one frame_err pulse; rx_level stays 0.
REQ-037 Receive 5 bytes with rx_ready=0 -> overrun pulse on the 5th byte; rx_level=4; head = first byte.
